// File: rtl/seg_display_if.sv
// Bus between the MMIO output register block and the 8-digit 7-segment scan controller.
// update is a one-cycle strobe with no back-pressure; mode_select/alu_result* are sampled only while it is high.
interface seg_display_if;
    logic        update;
    logic [3:0]  mode_select;
    logic [31:0] alu_result0;
    logic [31:0] alu_result1;
    logic [7:0]  seg_an;
    logic [7:0]  seg_cat;
    logic        page;

    modport master (
        output update, mode_select, alu_result0, alu_result1,
        input  seg_an, seg_cat, page
    );

    modport slave (
        input  update, mode_select, alu_result0, alu_result1,
        output seg_an, seg_cat, page
    );
endinterface

// File: rtl/seg_display_ctrl.sv
// Frame-synchronous scan controller for an 8-digit 7-segment display fed from MMIO result registers.
// Optional: define SEG_DP_PAGE_EN to light the digit-7 decimal point while page 1 is shown in auto mode.
module seg_display_ctrl #(
    parameter int SCAN_DIV    = 100000,
    parameter int PAGE_FRAMES = 400
) (
    input logic          clk,
    input logic          rst,
    seg_display_if.slave bus
);
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FW = $clog2(PAGE_FRAMES + 1);
    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(PAGE_FRAMES - 1);
    localparam logic [3:0]    MODE_AUTO  = 4'd2;

    logic [SW-1:0] scan_q, scan_d;
    logic [2:0]    digit_q, digit_d;
    logic [FW-1:0] frame_q, frame_d;
    logic          page_q, page_d;
    logic          pend_q, pend_d;
    logic [3:0]    stg_mode_q, stg_mode_d, shd_mode_q, shd_mode_d;
    logic [31:0]   stg_r0_q, stg_r0_d, stg_r1_q, stg_r1_d;
    logic [31:0]   shd_r0_q, shd_r0_d, shd_r1_q, shd_r1_d;
    logic [7:0]    seg_an_q, seg_an_d, seg_cat_q, seg_cat_d;

    logic          frame_end;
    logic [3:0]    next_mode;
    logic [31:0]   word;
    logic [3:0]    nib;
    logic [6:0]    glyph;
    logic          dp;

    function automatic logic [6:0] hex_glyph(input logic [3:0] v);
        case (v)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    always_comb begin
        scan_d     = scan_q;
        digit_d    = digit_q;
        frame_d    = frame_q;
        page_d     = page_q;
        pend_d     = pend_q;
        stg_mode_d = stg_mode_q;
        stg_r0_d   = stg_r0_q;
        stg_r1_d   = stg_r1_q;
        shd_mode_d = shd_mode_q;
        shd_r0_d   = shd_r0_q;
        shd_r1_d   = shd_r1_q;

        frame_end = (scan_q == SCAN_LAST) && (digit_q == 3'd7);
        next_mode = pend_q ? stg_mode_q : shd_mode_q;

        if (scan_q == SCAN_LAST) begin
            scan_d  = '0;
            digit_d = digit_q + 3'd1;
        end else begin
            scan_d  = scan_q + SW'(1);
        end

        // Shadow swap and page bookkeeping happen only at frame end so a frame never tears.
        if (frame_end) begin
            if (pend_q) begin
                shd_mode_d = stg_mode_q;
                shd_r0_d   = stg_r0_q;
                shd_r1_d   = stg_r1_q;
                pend_d     = 1'b0;
            end
            if ((shd_mode_q == MODE_AUTO) && (next_mode == MODE_AUTO)) begin
                if (frame_q == FRAME_LAST) begin
                    frame_d = '0;
                    page_d  = ~page_q;
                end else begin
                    frame_d = frame_q + FW'(1);
                end
            end else begin
                frame_d = '0;
                page_d  = 1'b0;
            end
        end

        // Staging capture comes after the swap so a coinciding update waits for the next frame end.
        if (bus.update) begin
            stg_mode_d = bus.mode_select;
            stg_r0_d   = bus.alu_result0;
            stg_r1_d   = bus.alu_result1;
            pend_d     = 1'b1;
        end

        case (shd_mode_q)
            4'd0:    word = shd_r0_q;
            4'd1:    word = shd_r1_q;
            4'd2:    word = page_q ? shd_r1_q : shd_r0_q;
            4'd3:    word = {shd_r1_q[15:0], shd_r0_q[15:0]};
            default: word = {28'h0, shd_mode_q};
        endcase
        nib = word[{digit_q, 2'b00} +: 4];
        if ((shd_mode_q >= 4'd4) && (digit_q != 3'd0)) glyph = 7'h7F;
        else                                            glyph = hex_glyph(nib);

        dp = 1'b1;
`ifdef SEG_DP_PAGE_EN
        if ((shd_mode_q == MODE_AUTO) && page_q && (digit_q == 3'd7)) dp = 1'b0;
`else
        dp = 1'b1;
`endif

        seg_an_d  = (scan_q == '0) ? 8'hFF : ~(8'h01 << digit_q);
        seg_cat_d = {dp, glyph};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_q     <= '0;
            digit_q    <= '0;
            frame_q    <= '0;
            page_q     <= 1'b0;
            pend_q     <= 1'b0;
            stg_mode_q <= '0;
            stg_r0_q   <= '0;
            stg_r1_q   <= '0;
            shd_mode_q <= '0;
            shd_r0_q   <= '0;
            shd_r1_q   <= '0;
            seg_an_q   <= 8'hFF;
            seg_cat_q  <= 8'hFF;
        end else begin
            scan_q     <= scan_d;
            digit_q    <= digit_d;
            frame_q    <= frame_d;
            page_q     <= page_d;
            pend_q     <= pend_d;
            stg_mode_q <= stg_mode_d;
            stg_r0_q   <= stg_r0_d;
            stg_r1_q   <= stg_r1_d;
            shd_mode_q <= shd_mode_d;
            shd_r0_q   <= shd_r0_d;
            shd_r1_q   <= shd_r1_d;
            seg_an_q   <= seg_an_d;
            seg_cat_q  <= seg_cat_d;
        end
    end

    assign bus.seg_an  = seg_an_q;
    assign bus.seg_cat = seg_cat_q;
    assign bus.page    = page_q;
endmodule
